// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port RAM between the CPU fetch port and the MEM-stage data port:
// arbitrates, drives the RAM, times the fixed-latency return and routes the response.
module imem_dmem_arbiter #(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned AW         = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wstrb,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [31:0]   mem_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam int unsigned LCW = $clog2(RD_LAT + 1);
  localparam int unsigned SCW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nxt;
  logic           owner, owner_nxt;          // 0 = IF, 1 = MEM
  logic [LCW-1:0] lat_cnt, lat_cnt_nxt;
  logic           kill_pend, kill_pend_nxt;
  logic           wr_pend, wr_pend_nxt;
  logic [SCW-1:0] starve_cnt, starve_cnt_nxt;

  logic slot, resp, if_elig, win_mem, win_if;

  // State and bookkeeping registers; reset drops any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      lat_cnt    <= '0;
      kill_pend  <= 1'b0;
      wr_pend    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_cnt    <= lat_cnt_nxt;
      kill_pend  <= kill_pend_nxt;
      wr_pend    <= wr_pend_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Next state, arbitration, RAM drive and response routing
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    lat_cnt_nxt    = lat_cnt;
    kill_pend_nxt  = kill_pend;
    wr_pend_nxt    = wr_pend;
    starve_cnt_nxt = starve_cnt;
    if_gnt         = 1'b0;
    if_rvalid      = 1'b0;
    if_rdata       = '0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    ram_en         = 1'b0;
    ram_we         = '0;
    ram_addr       = '0;
    ram_wdata      = '0;

    // Outputs are gated by reset so they drop immediately on an async assert
    slot    = !reset && ((state == IDLE) || (lat_cnt == '0));
    resp    = !reset && (state == BUSY) && (lat_cnt == '0);
    if_elig = if_req && !if_kill;
    win_mem = slot && mem_req && !(if_elig && (starve_cnt == SCW'(STARVE_MAX)));
    win_if  = slot && if_elig && !win_mem;

    if (resp) begin
      if (owner) begin
        mem_rvalid = 1'b1;
        mem_rdata  = wr_pend ? 32'h0 : ram_rdata;
      end else if (!kill_pend && !if_kill) begin
        if_rvalid = 1'b1;
        if_rdata  = ram_rdata;
      end
      state_nxt     = IDLE;
      kill_pend_nxt = 1'b0;
    end else if (state == BUSY) begin
      lat_cnt_nxt = lat_cnt - LCW'(1);
      if (!owner && if_kill) kill_pend_nxt = 1'b1;
    end

    if (win_mem || win_if) begin
      ram_en        = 1'b1;
      ram_addr      = win_mem ? mem_addr : if_addr;
      ram_wdata     = mem_wdata;
      ram_we        = (win_mem && mem_we) ? mem_wstrb : 4'b0000;
      if_gnt        = win_if;
      mem_gnt       = win_mem;
      state_nxt     = BUSY;
      owner_nxt     = win_mem;
      lat_cnt_nxt   = LCW'(RD_LAT - 1);
      kill_pend_nxt = 1'b0;
      wr_pend_nxt   = win_mem && mem_we;
    end

    // IF starvation tracking: count MEM wins over an eligible fetch
    if (win_if) begin
      starve_cnt_nxt = '0;
    end else if (win_mem && if_elig && (starve_cnt != SCW'(STARVE_MAX))) begin
      starve_cnt_nxt = starve_cnt + SCW'(1);
    end
  end

endmodule
